// File: rtl/fifo_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_unpacker_pkg
// Brief    : State encoding and lane-geometry helpers for fifo_unpacker.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_unpacker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2
  } state_t;

  localparam int MIN_LANES = 2;

  function automatic int lane_count(input int data_width, input int out_width);
    return data_width / out_width;
  endfunction

  // Word must split into a whole number of lanes, and into at least two of them.
  function automatic bit widths_ok(input int data_width, input int out_width);
    return (out_width > 0) && (data_width % out_width == 0) &&
           (data_width / out_width >= MIN_LANES);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_unpacker_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_unpacker_if
// Brief    : FIFO read side plus lane stream handshake of the unpacker.
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_unpacker_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int COUNT_WIDTH = 16
);

  logic [DATA_WIDTH-1:0]  fifo_q;
  logic                   fifo_empty;
  logic                   fifo_read_enable;
  logic [OUT_WIDTH-1:0]   out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;
  logic [COUNT_WIDTH-1:0] words_sent;

  modport master (
    input  fifo_q, fifo_empty, out_ready,
    output fifo_read_enable, out_data, out_valid, out_last, words_sent
  );

  modport slave (
    output fifo_q, fifo_empty, out_ready,
    input  fifo_read_enable, out_data, out_valid, out_last, words_sent
  );

endinterface
`default_nettype wire

// File: rtl/fifo_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : fifo_unpacker
// Brief    : Pops FIFO words and emits them as OUT_WIDTH lanes (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_unpacker
  import fifo_unpacker_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int MSB_FIRST   = 1,
  parameter int COUNT_WIDTH = 16
) (
  input  wire logic        clock,
  input  wire logic        reset,
  fifo_unpacker_if.master  bus
);

  localparam int LANES  = lane_count(DATA_WIDTH, OUT_WIDTH);
  localparam int LANE_W = $clog2(LANES);
  localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(LANES - 1);

  generate
    if (!widths_ok(DATA_WIDTH, OUT_WIDTH)) begin : g_bad_widths
      $error("fifo_unpacker: DATA_WIDTH must be a multiple (>=2x) of OUT_WIDTH");
    end
  endgenerate

  state_t                 r_state;
  state_t                 w_next;
  logic [DATA_WIDTH-1:0]  r_hold;
  logic [LANE_W-1:0]      r_lane;
  logic [COUNT_WIDTH-1:0] r_words_sent;
  logic                   w_valid;
  logic                   w_read_enable;
  logic                   w_is_last;
  logic                   w_xfer;
  logic [OUT_WIDTH-1:0]   w_lane_data;

  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_lane_data = r_hold[DATA_WIDTH - 1 - int'(r_lane) * OUT_WIDTH -: OUT_WIDTH];
    end else begin : g_lsb_first
      assign w_lane_data = r_hold[int'(r_lane) * OUT_WIDTH +: OUT_WIDTH];
    end
  endgenerate

  assign w_is_last = (r_lane == C_LAST_LANE);
  assign w_xfer    = w_valid && bus.out_ready;

  always_comb begin
    w_next        = r_state;
    w_valid       = 1'b0;
    w_read_enable = 1'b0;
    case (r_state)
      IDLE: begin
        w_read_enable = !bus.fifo_empty;
        if (!bus.fifo_empty) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        w_next = SEND;
      end
      SEND: begin
        w_valid = 1'b1;
        // Popping on the last transfer hides one cycle of FIFO read latency.
        if (w_xfer && w_is_last) begin
          if (!bus.fifo_empty) begin
            w_read_enable = 1'b1;
            w_next        = WAIT;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    if (reset) begin
      w_read_enable = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_lane       <= '0;
      r_words_sent <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == WAIT) begin
        r_hold <= bus.fifo_q;
        r_lane <= '0;
      end
      if (w_xfer) begin
        if (w_is_last) begin
          r_words_sent <= r_words_sent + COUNT_WIDTH'(1);
        end else begin
          r_lane <= r_lane + LANE_W'(1);
        end
      end
    end
  end

  assign bus.fifo_read_enable = w_read_enable;
  assign bus.out_valid        = w_valid;
  assign bus.out_last         = w_valid && w_is_last;
  assign bus.out_data         = w_valid ? w_lane_data : '0;
  assign bus.words_sent       = r_words_sent;

endmodule
`default_nettype wire

// File: tb/tb_fifo_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_unpacker
// Brief    : Directed self-checking bench for fifo_unpacker (three configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_unpacker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        out_ready = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_q = '0;
  logic [31:0] fifo_mem[$];
  int          pops = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clock = ~clock;

  fifo_unpacker_if #(.DATA_WIDTH(32), .OUT_WIDTH(8), .COUNT_WIDTH(16)) if_a ();
  fifo_unpacker_if #(.DATA_WIDTH(32), .OUT_WIDTH(8), .COUNT_WIDTH(16)) if_b ();
  fifo_unpacker_if #(.DATA_WIDTH(32), .OUT_WIDTH(8), .COUNT_WIDTH(2))  if_c ();

  // All three instances see identical stimulus; only if_a drives the FIFO model.
  assign if_a.fifo_q = fifo_q;  assign if_a.fifo_empty = fifo_empty;  assign if_a.out_ready = out_ready;
  assign if_b.fifo_q = fifo_q;  assign if_b.fifo_empty = fifo_empty;  assign if_b.out_ready = out_ready;
  assign if_c.fifo_q = fifo_q;  assign if_c.fifo_empty = fifo_empty;  assign if_c.out_ready = out_ready;

  fifo_unpacker #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1), .COUNT_WIDTH(16)) dut_a (
    .clock(clock), .reset(reset), .bus(if_a.master));
  fifo_unpacker #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(0), .COUNT_WIDTH(16)) dut_b (
    .clock(clock), .reset(reset), .bus(if_b.master));
  fifo_unpacker #(.DATA_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1), .COUNT_WIDTH(2)) dut_c (
    .clock(clock), .reset(reset), .bus(if_c.master));

  task automatic push(input logic [31:0] w);
    fifo_mem.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle including the FIFO model: data appears the cycle after a pop.
  task automatic tick();
    logic re;
    logic was_reset;
    #2;
    re        = if_a.fifo_read_enable;
    was_reset = reset;
    if (re) begin
      checks++;
      if (fifo_empty) begin
        errors++;
        $display("FAIL pop_while_empty read_enable=%0b fifo_empty=%0b", re, fifo_empty);
      end
    end
    @(posedge clock);
    #1;
    if (was_reset) begin
      fifo_mem.delete();
    end else if (re && fifo_mem.size() > 0) begin
      fifo_q = fifo_mem.pop_front();
      pops++;
    end
    fifo_empty = (fifo_mem.size() == 0);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    pops  = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(32'hDEAD_BEEF);
      #1;
      checks++;
      if (if_a.fifo_read_enable !== 1'b0) begin
        errors++;
        $display("FAIL reset_read_enable cycle%0d got=%0b exp=0", i, if_a.fifo_read_enable);
      end
      tick();
    end
    reset = 1'b0;
    pops  = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({if_a.out_valid, if_a.out_last, if_a.out_data, if_a.words_sent, if_a.fifo_read_enable} !== '0) begin
        errors++;
        $display("FAIL reset_outputs valid=%0b last=%0b data=%h words=%0d rd=%0b exp all 0",
                 if_a.out_valid, if_a.out_last, if_a.out_data, if_a.words_sent, if_a.fifo_read_enable);
      end
      tick();
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp_lane[4];
    exp_lane[0] = 8'hA1; exp_lane[1] = 8'hB2; exp_lane[2] = 8'hC3; exp_lane[3] = 8'hD4;
    apply_reset();
    push(32'hA1B2_C3D4);
    #1;
    checks++;
    if (if_a.fifo_read_enable !== 1'b1) begin
      errors++;
      $display("FAIL single_pop got=%0b exp=1", if_a.fifo_read_enable);
    end
    tick();
    checks++;
    if (if_a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_wait_valid got=%0b exp=0", if_a.out_valid);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== exp_lane[i] || if_a.out_last !== (i == 3)) begin
        errors++;
        $display("FAIL single_lane%0d got valid=%0b data=%h last=%0b exp valid=1 data=%h last=%0b",
                 i, if_a.out_valid, if_a.out_data, if_a.out_last, exp_lane[i], (i == 3));
      end
      tick();
    end
    tick();
    tick();
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.words_sent !== 16'd1 || pops != 1) begin
      errors++;
      $display("FAIL single_after got valid=%0b words=%0d pops=%0d exp valid=0 words=1 pops=1",
               if_a.out_valid, if_a.words_sent, pops);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    push(32'hA1B2_C3D4);
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== 8'hB2 || if_a.out_last !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold step%0d got valid=%0b data=%h last=%0b exp valid=1 data=b2 last=0",
                 i, if_a.out_valid, if_a.out_data, if_a.out_last);
      end
      if (i < 3) tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (if_a.out_data !== 8'hC3) begin
      errors++;
      $display("FAIL backpressure_c3 got=%h exp=c3", if_a.out_data);
    end
    tick();
    checks++;
    if (if_a.out_data !== 8'hD4 || if_a.out_last !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_d4_cycle8 got data=%h last=%0b exp data=d4 last=1", if_a.out_data, if_a.out_last);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_lane[8];
    exp_lane[0] = 8'h11; exp_lane[1] = 8'h22; exp_lane[2] = 8'h33; exp_lane[3] = 8'h44;
    exp_lane[4] = 8'h55; exp_lane[5] = 8'h66; exp_lane[6] = 8'h77; exp_lane[7] = 8'h88;
    apply_reset();
    push(32'h1122_3344);
    push(32'h5566_7788);
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if (if_a.out_valid !== 1'b1 || if_a.out_data !== exp_lane[i] || if_a.out_last !== (i % 4 == 3) ||
          if_a.fifo_read_enable !== (i == 3)) begin
        errors++;
        $display("FAIL b2b_lane%0d got valid=%0b data=%h last=%0b rd=%0b exp valid=1 data=%h last=%0b rd=%0b",
                 i, if_a.out_valid, if_a.out_data, if_a.out_last, if_a.fifo_read_enable,
                 exp_lane[i], (i % 4 == 3), (i == 3));
      end
      tick();
      if (i == 3) begin
        checks++;
        if (if_a.out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_bubble got valid=%0b exp=0", if_a.out_valid);
        end
        tick();
      end
    end
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.words_sent !== 16'd2 || pops != 2) begin
      errors++;
      $display("FAIL b2b_after got valid=%0b words=%0d pops=%0d exp valid=0 words=2 pops=2",
               if_a.out_valid, if_a.words_sent, pops);
    end
  endtask

  task automatic test_lane_order();
    logic [7:0] exp_lane[4];
    exp_lane[0] = 8'hD4; exp_lane[1] = 8'hC3; exp_lane[2] = 8'hB2; exp_lane[3] = 8'hA1;
    apply_reset();
    push(32'hA1B2_C3D4);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (if_b.out_valid !== 1'b1 || if_b.out_data !== exp_lane[i] || if_b.out_last !== (i == 3)) begin
        errors++;
        $display("FAIL lsb_first_lane%0d got valid=%0b data=%h last=%0b exp valid=1 data=%h last=%0b",
                 i, if_b.out_valid, if_b.out_data, if_b.out_last, exp_lane[i], (i == 3));
      end
      tick();
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    for (int i = 0; i < 5; i++) push(32'h0102_0304 + 32'(i));
    for (int i = 0; i < 30; i++) tick();
    checks++;
    if (if_a.words_sent !== 16'd5 || if_c.words_sent !== 2'd1 || pops != 5) begin
      errors++;
      $display("FAIL counter_wrap got a=%0d c=%0d pops=%0d exp a=5 c=1 pops=5",
               if_a.words_sent, if_c.words_sent, pops);
    end
  endtask

  task automatic test_reset_mid_word();
    push(32'hA1B2_C3D4);
    tick();
    tick();
    tick();
    tick();
    checks++;
    if (if_a.out_data !== 8'hC3) begin
      errors++;
      $display("FAIL midword_setup got=%h exp=c3", if_a.out_data);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (if_a.out_valid !== 1'b0 || if_a.out_data !== 8'h00 || if_a.words_sent !== 16'd0 ||
        if_c.words_sent !== 2'd0) begin
      errors++;
      $display("FAIL midword_reset got valid=%0b data=%h a=%0d c=%0d exp valid=0 data=00 a=0 c=0",
               if_a.out_valid, if_a.out_data, if_a.words_sent, if_c.words_sent);
    end
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_backpressure();
    test_back_to_back();
    test_lane_order();
    test_counter_wrap();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
